// File: rtl/fabric_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fabric_mem_arbiter_pkg
// Shared definitions for the fabric scratchpad load-port arbiter:
//   - RT_MEMARB_* error codes reported on error_code
//   - error classification enum and helpers that pick and encode the error
//     to latch when several conditions are detected in the same cycle
// -----------------------------------------------------------------------------
package fabric_mem_arbiter_pkg;

  // Runtime error codes, kept alongside the other fabric RT_* codes.
  localparam logic [15:0] RT_MEMARB_TAG_OOB   = 16'h0A01;
  localparam logic [15:0] RT_MEMARB_UNDERFLOW = 16'h0A02;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_TAG_OOB   = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } memarb_err_e;

  // A bad tag outranks an underflow seen in the same cycle.
  function automatic memarb_err_e memarb_err_pick(input logic oob, input logic unf);
    memarb_err_e sel;
    if (oob) begin
      sel = ERR_TAG_OOB;
    end else if (unf) begin
      sel = ERR_UNDERFLOW;
    end else begin
      sel = ERR_NONE;
    end
    return sel;
  endfunction

  function automatic logic [15:0] memarb_err_code(input memarb_err_e err);
    logic [15:0] code;
    case (err)
      ERR_TAG_OOB:   code = RT_MEMARB_TAG_OOB;
      ERR_UNDERFLOW: code = RT_MEMARB_UNDERFLOW;
      default:       code = 16'h0000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fabric_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// fabric_rr_arbiter
// Generic round-robin arbiter that owns its rotating priority pointer.
// The search starts at the pointer and wraps modulo N; on advance the pointer
// moves to one past the granted index. Reusable by load, store and LSQ sides.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointer -> 0)
//   eligible[N]   per-requester eligibility
//   advance       the current grant was consumed this cycle
//   grant_valid   at least one requester is eligible
//   grant_idx     index of the granted requester
// -----------------------------------------------------------------------------
module fabric_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     eligible,
  input  logic             advance,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_r;
  logic             grant_valid_s;
  logic [IDX_W-1:0] grant_idx_s;

  // First eligible index at or after ptr_r, wrapping past N-1 back to 0.
  always_comb begin : search
    int cand;
    grant_valid_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    cand          = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_r) + k;
      cand = (cand >= N) ? (cand - N) : cand;
      if (!grant_valid_s && eligible[cand]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = IDX_W'(cand);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Rotate priority to just past the winner whenever a grant is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (advance) begin
      ptr_r <= (int'(grant_idx_s) == N - 1) ? {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
    end
  end

  assign grant_valid = grant_valid_s;
  assign grant_idx   = grant_idx_s;

endmodule

// File: rtl/fabric_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fabric_mem_arbiter
// Shares one tagged load port of the fabric scratchpad among NUM_REQ
// requesters. One request per cycle is picked round-robin and forwarded with
// the requester index as its tag; responses are steered back by tag. Each
// requester may have at most MAX_OUTSTANDING loads in flight.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/ready/addr    per-requester load request stream
//   mem_req_valid/ready     request to memory load port
//   mem_req_addr/tag        forwarded address and requester index
//   mem_rsp_valid/ready     response from memory load port
//   mem_rsp_data/tag        load data and echoed tag
//   rsp_valid/ready         per-requester response handshake
//   rsp_data                load data broadcast to all requesters
//   error_valid/error_code  sticky first error (TAG_OOB beats UNDERFLOW)
// Configuration:
//   FABRIC_MEM_ARB_REQ_REG_EN  defined: 1-entry register slice on mem_req_*
//                              (1-cycle request latency, no bubbles).
//                              undefined: mem_req_* driven from the grant mux.
// -----------------------------------------------------------------------------
module fabric_mem_arbiter
  import fabric_mem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int ADDR_WIDTH      = 6,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int TAG_W           = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr,
  output logic [TAG_W-1:0]                    mem_req_tag,
  input  logic                                mem_rsp_valid,
  output logic                                mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]               mem_rsp_data,
  input  logic [TAG_W-1:0]                    mem_rsp_tag,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_data,
  output logic                                error_valid,
  output logic [15:0]                         error_code
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "fabric_mem_arbiter: NUM_REQ must be >= 2");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
    $fatal(1, "fabric_mem_arbiter: MAX_OUTSTANDING must be >= 1");
  end

  logic [CNT_W-1:0]   cnt_r [NUM_REQ];
  logic [NUM_REQ-1:0] eligible_s;
  logic               grant_valid_s;
  logic [TAG_W-1:0]   grant_idx_s;
  logic               can_accept_s;
  logic               issue_fire_s;
  logic               tag_ok_s;
  logic               rsp_sel_ready_s;
  logic               rsp_sel_zero_s;
  logic               rsp_fire_s;
  logic               oob_s;
  logic               underflow_s;
  logic [NUM_REQ-1:0] inc_vec_s;
  logic [NUM_REQ-1:0] dec_vec_s;
  memarb_err_e        err_sel_s;
  logic               error_valid_r;
  logic [15:0]        error_code_r;

  // A requester competes only while it has a free outstanding slot.
  always_comb begin
    eligible_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid[i] && (cnt_r[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  fabric_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .eligible    (eligible_s),
    .advance     (issue_fire_s),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Gated by rst_n so no handshake leaks out while reset is held.
  assign issue_fire_s = rst_n && grant_valid_s && can_accept_s;

  // One-hot ready on the winner, and only when the issue actually happens.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = issue_fire_s && (grant_idx_s == TAG_W'(i));
    end
  end

`ifdef FABRIC_MEM_ARB_REQ_REG_EN
  logic                  slice_valid_r;
  logic [ADDR_WIDTH-1:0] slice_addr_r;
  logic [TAG_W-1:0]      slice_tag_r;

  // Reload while draining keeps back-to-back issue bubble-free.
  assign can_accept_s = !slice_valid_r || mem_req_ready;

  // Single-entry request slice: load on issue, empty when memory accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_valid_r <= 1'b0;
      slice_addr_r  <= {ADDR_WIDTH{1'b0}};
      slice_tag_r   <= {TAG_W{1'b0}};
    end else if (issue_fire_s) begin
      slice_valid_r <= 1'b1;
      slice_addr_r  <= req_addr[grant_idx_s];
      slice_tag_r   <= grant_idx_s;
    end else if (mem_req_ready) begin
      slice_valid_r <= 1'b0;
    end
  end

  assign mem_req_valid = rst_n && slice_valid_r;
  assign mem_req_addr  = slice_addr_r;
  assign mem_req_tag   = slice_tag_r;
`else
  assign can_accept_s  = mem_req_ready;
  assign mem_req_valid = rst_n && grant_valid_s;
  assign mem_req_addr  = req_addr[grant_idx_s];
  assign mem_req_tag   = grant_idx_s;
`endif

  // Tags beyond NUM_REQ-1 are only possible when NUM_REQ is not a power of 2.
  assign tag_ok_s = (int'(mem_rsp_tag) < NUM_REQ);

  // Steer the response to the tagged requester and pick its ready/count.
  always_comb begin
    rsp_valid       = {NUM_REQ{1'b0}};
    rsp_sel_ready_s = 1'b0;
    rsp_sel_zero_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_data[i] = mem_rsp_data;
      if (tag_ok_s && (mem_rsp_tag == TAG_W'(i))) begin
        rsp_valid[i]    = rst_n && mem_rsp_valid;
        rsp_sel_ready_s = rsp_ready[i];
        rsp_sel_zero_s  = (cnt_r[i] == {CNT_W{1'b0}});
      end else begin
        rsp_valid[i]    = 1'b0;
      end
    end
  end

  // Bad tags are swallowed so they cannot block the memory response path.
  assign mem_rsp_ready = rst_n && (tag_ok_s ? rsp_sel_ready_s : 1'b1);
  assign rsp_fire_s    = mem_rsp_valid && mem_rsp_ready && tag_ok_s;
  assign oob_s         = rst_n && mem_rsp_valid && !tag_ok_s;
  assign underflow_s   = rsp_fire_s && rsp_sel_zero_s;

  // Per-requester increment/decrement; a decrement at zero is suppressed.
  always_comb begin
    inc_vec_s = {NUM_REQ{1'b0}};
    dec_vec_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_vec_s[i] = issue_fire_s && (grant_idx_s == TAG_W'(i));
      dec_vec_s[i] = rsp_fire_s && (mem_rsp_tag == TAG_W'(i)) &&
                     (cnt_r[i] != {CNT_W{1'b0}});
    end
  end

  // Outstanding-load counters; simultaneous issue and response cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc_vec_s[i] && !dec_vec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else if (!inc_vec_s[i] && dec_vec_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end
      end
    end
  end

  assign err_sel_s = memarb_err_pick(oob_s, underflow_s);

  // Sticky error latch: keeps the first error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_valid_r <= 1'b0;
      error_code_r  <= 16'h0000;
    end else if (!error_valid_r && (err_sel_s != ERR_NONE)) begin
      error_valid_r <= 1'b1;
      error_code_r  <= memarb_err_code(err_sel_s);
    end
  end

  assign error_valid = error_valid_r;
  assign error_code  = error_code_r;

endmodule
